// File: rtl/password_setter.sv
// Password programming front end: debounced set/enter buttons, double-entry
// confirmation of a 4-digit code, and a small 7-segment status display.

module password_setter_btn #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic          level;
    logic [CW-1:0] cnt;

    // The level flips only after the synchronized input has disagreed with it
    // for DB_CYCLES straight cycles; a rising flip emits a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            pulse <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                level <= s2;
                cnt   <= '0;
                pulse <= s2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module password_setter #(
    parameter int          DIGITS       = 4,
    parameter int          DB_CYCLES    = 16,
    parameter int          HOLD_CYCLES  = 32,
    parameter int          REFRESH_BITS = 16,
    parameter logic [15:0] DEFAULT_CODE = 16'h0101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sw,
    input  logic        btn_set,
    input  logic        btn_enter,
    output logic [15:0] code,
    output logic        code_valid,
    output logic        busy,
    output logic [6:0]  seg,
    output logic [3:0]  an
);
    typedef enum logic [2:0] {IDLE, ENTER1, ENTER2, CHECK, OK, ERR} state_t;

    localparam int         HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [1:0] LAST      = 2'(DIGITS - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    state_t                  state;
    logic [1:0]              idx;
    logic [15:0]             buf1;
    logic [15:0]             buf2;
    logic [HW-1:0]           hold;
    logic [REFRESH_BITS-1:0] scan;
    logic [1:0]              pos;
    logic                    set_p;
    logic                    enter_p;

    password_setter_btn #(.DB_CYCLES(DB_CYCLES)) u_set (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_set),
        .pulse (set_p)
    );

    password_setter_btn #(.DB_CYCLES(DB_CYCLES)) u_enter (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_enter),
        .pulse (enter_p)
    );

    assign pos = scan[REFRESH_BITS-1 -: 2];

    // code_valid drops during the CHECK cycle only when that CHECK is about to
    // overwrite code, so the checker never sees a half-updated password.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 2'd0;
            buf1       <= 16'h0000;
            buf2       <= 16'h0000;
            hold       <= '0;
            code       <= DEFAULT_CODE;
            code_valid <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (set_p) begin
                        state <= ENTER1;
                        idx   <= 2'd0;
                        buf1  <= 16'h0000;
                        busy  <= 1'b1;
                    end
                end
                ENTER1: begin
                    if (set_p) begin
                        idx  <= 2'd0;
                        buf1 <= 16'h0000;
                    end else if (enter_p) begin
                        buf1[{idx, 2'b00} +: 4] <= sw;
                        if (idx == LAST) begin
                            state <= ENTER2;
                            idx   <= 2'd0;
                            buf2  <= 16'h0000;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                ENTER2: begin
                    if (set_p) begin
                        state <= ENTER1;
                        idx   <= 2'd0;
                        buf1  <= 16'h0000;
                    end else if (enter_p) begin
                        buf2[{idx, 2'b00} +: 4] <= sw;
                        if (idx == LAST) begin
                            state      <= CHECK;
                            idx        <= 2'd0;
                            code_valid <= ({sw, buf2[11:0]} != buf1);
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                CHECK: begin
                    code_valid <= 1'b1;
                    busy       <= 1'b0;
                    hold       <= '0;
                    if (buf1 == buf2) begin
                        code  <= buf1;
                        state <= OK;
                    end else begin
                        state <= ERR;
                    end
                end
                OK, ERR: begin
                    if (set_p) begin
                        state <= ENTER1;
                        idx   <= 2'd0;
                        buf1  <= 16'h0000;
                        busy  <= 1'b1;
                        hold  <= '0;
                    end else if (hold == HW'(HOLD_CYCLES - 1)) begin
                        state <= IDLE;
                        hold  <= '0;
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Multiplexed display: one position lit per scan slot, glyph chosen by state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan <= '0;
            an   <= 4'b1111;
            seg  <= SEG_BLANK;
        end else begin
            scan <= scan + REFRESH_BITS'(1);
            an   <= ~(4'b0001 << pos);
            case (state)
                ENTER1, ENTER2: seg <= (pos < idx) ? SEG_DASH : SEG_BLANK;
                CHECK:          seg <= SEG_DASH;
                OK:             seg <= SEG_P;
                ERR:            seg <= SEG_E;
                default: begin
                    an  <= 4'b1111;
                    seg <= SEG_BLANK;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_password_setter.sv
// Directed bench for password_setter: reset, program, mismatch, bounce,
// restart and reset-during-entry scenarios with hand-computed expectations.

module tb_password_setter;
    localparam int DB   = 4;
    localparam int HOLD = 64;
    localparam int RB   = 4;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_P = 7'b0001100;
    localparam logic [6:0] GLYPH_E = 7'b0000110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sw = 4'h0;
    logic        btn_set = 1'b0;
    logic        btn_enter = 1'b0;
    logic [15:0] code;
    logic        code_valid;
    logic        busy;
    logic [6:0]  seg;
    logic [3:0]  an;

    int vectors = 0;
    int errors  = 0;
    int cv_low  = 0;
    int cv_mark = 0;

    logic [6:0] disp [4];
    logic [3:0] seen;
    logic [6:0] want [4];

    password_setter #(
        .DIGITS       (4),
        .DB_CYCLES    (DB),
        .HOLD_CYCLES  (HOLD),
        .REFRESH_BITS (RB),
        .DEFAULT_CODE (16'h0101)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .btn_set    (btn_set),
        .btn_enter  (btn_enter),
        .code       (code),
        .code_valid (code_valid),
        .busy       (busy),
        .seg        (seg),
        .an         (an)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b0 && code_valid !== 1'b1) cv_low++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_set();
        btn_set = 1'b1;
        tick(10);
        btn_set = 1'b0;
        tick(10);
    endtask

    task automatic press_enter(input logic [3:0] d);
        sw = d;
        btn_enter = 1'b1;
        tick(10);
        btn_enter = 1'b0;
        tick(10);
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < 4; i++) press_enter(c[4*i +: 4]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic scan_display();
        seen = 4'b0000;
        for (int i = 0; i < 4; i++) disp[i] = 7'bx;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            case (an)
                4'b1110: begin disp[0] = seg; seen[0] = 1'b1; end
                4'b1101: begin disp[1] = seg; seen[1] = 1'b1; end
                4'b1011: begin disp[2] = seg; seen[2] = 1'b1; end
                4'b0111: begin disp[3] = seg; seen[3] = 1'b1; end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (code !== 16'h0101) begin errors++; $display("[TB] FAIL reset_code: got %h expected 0101", code); end
        vectors++;
        if (code_valid !== 1'b1) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 1", code_valid); end
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        vectors++;
        if (an !== 4'hF || seg !== BLANK) begin errors++; $display("[TB] FAIL reset_display: got an=%h seg=%h expected an=f seg=7f", an, seg); end

        press_enter(4'h9);
        vectors++;
        if (busy !== 1'b0 || an !== 4'hF) begin errors++; $display("[TB] FAIL idle_enter_ignored: got busy=%b an=%h expected busy=0 an=f", busy, an); end

        press_set();
        press_enter(4'h5);
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrun_busy: got %b expected 1", busy); end
        do_reset();
        vectors++;
        if (code !== 16'h0101 || code_valid !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL midrun_reset: got code=%h valid=%b busy=%b expected 0101/1/0", code, code_valid, busy);
        end
        vectors++;
        if (an !== 4'hF || seg !== BLANK) begin errors++; $display("[TB] FAIL midrun_reset_display: got an=%h seg=%h expected f/7f", an, seg); end
    endtask

    task automatic test_program();
        cv_mark = cv_low;
        press_set();
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL prog_busy_set: got %b expected 1", busy); end
        scan_display();
        for (int p = 0; p < 4; p++) begin
            vectors++;
            if (seen[p] !== 1'b1 || disp[p] !== BLANK) begin errors++; $display("[TB] FAIL prog_blank_pos%0d: got %h expected 7f", p, disp[p]); end
        end
        press_enter(4'h3);
        press_enter(4'h7);
        scan_display();
        want[0] = DASH; want[1] = DASH; want[2] = BLANK; want[3] = BLANK;
        for (int p = 0; p < 4; p++) begin
            vectors++;
            if (seen[p] !== 1'b1 || disp[p] !== want[p]) begin errors++; $display("[TB] FAIL prog_dash_pos%0d: got %h expected %h", p, disp[p], want[p]); end
        end
        press_enter(4'h0);
        press_enter(4'hF);
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL prog_busy_between: got %b expected 1", busy); end
        press_enter(4'h3);
        press_enter(4'h7);
        press_enter(4'h0);
        vectors++;
        if (busy !== 1'b1 || code !== 16'h0101) begin errors++; $display("[TB] FAIL prog_busy_enter2: got busy=%b code=%h expected 1/0101", busy, code); end
        press_enter(4'hF);
        vectors++;
        if (code !== 16'hF073) begin errors++; $display("[TB] FAIL prog_code: got %h expected f073", code); end
        vectors++;
        if (busy !== 1'b0 || code_valid !== 1'b1) begin errors++; $display("[TB] FAIL prog_ok_flags: got busy=%b valid=%b expected 0/1", busy, code_valid); end
        vectors++;
        if (cv_low - cv_mark !== 1) begin errors++; $display("[TB] FAIL prog_valid_dip: got %0d low cycles expected 1", cv_low - cv_mark); end
        scan_display();
        for (int p = 0; p < 4; p++) begin
            vectors++;
            if (seen[p] !== 1'b1 || disp[p] !== GLYPH_P) begin errors++; $display("[TB] FAIL prog_ok_pos%0d: got %h expected 0c", p, disp[p]); end
        end
        tick(HOLD + 10);
        vectors++;
        if (an !== 4'hF || seg !== BLANK || busy !== 1'b0 || code !== 16'hF073) begin
            errors++; $display("[TB] FAIL prog_idle: got an=%h seg=%h busy=%b code=%h expected f/7f/0/f073", an, seg, busy, code);
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        cv_mark = cv_low;
        press_set();
        enter_code(16'h4321);
        enter_code(16'h5321);
        vectors++;
        if (code !== 16'h0101 || code_valid !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL mis_flags: got code=%h valid=%b busy=%b expected 0101/1/0", code, code_valid, busy);
        end
        vectors++;
        if (cv_low - cv_mark !== 0) begin errors++; $display("[TB] FAIL mis_valid_dip: got %0d low cycles expected 0", cv_low - cv_mark); end
        scan_display();
        for (int p = 0; p < 4; p++) begin
            vectors++;
            if (seen[p] !== 1'b1 || disp[p] !== GLYPH_E) begin errors++; $display("[TB] FAIL mis_err_pos%0d: got %h expected 06", p, disp[p]); end
        end
        tick(HOLD + 10);
        vectors++;
        if (an !== 4'hF || busy !== 1'b0) begin errors++; $display("[TB] FAIL mis_idle: got an=%h busy=%b expected f/0", an, busy); end
    endtask

    task automatic test_bounce();
        press_set();
        sw = 4'hA;
        for (int i = 0; i < 10; i++) begin
            btn_enter = ~btn_enter;
            tick(2);
        end
        btn_enter = 1'b1;
        tick(50);
        btn_enter = 1'b0;
        tick(10);
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL bounce_busy: got %b expected 1", busy); end
        scan_display();
        want[0] = DASH; want[1] = BLANK; want[2] = BLANK; want[3] = BLANK;
        for (int p = 0; p < 4; p++) begin
            vectors++;
            if (seen[p] !== 1'b1 || disp[p] !== want[p]) begin errors++; $display("[TB] FAIL bounce_pos%0d: got %h expected %h", p, disp[p], want[p]); end
        end
    endtask

    task automatic test_restart();
        press_enter(4'hB);
        press_enter(4'hC);
        press_enter(4'hD);
        press_enter(4'h1);
        press_enter(4'h2);
        press_set();
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL restart_busy: got %b expected 1", busy); end
        enter_code(16'hDCBA);
        enter_code(16'hDCBA);
        vectors++;
        if (code !== 16'hDCBA || busy !== 1'b0) begin errors++; $display("[TB] FAIL restart_code: got code=%h busy=%b expected dcba/0", code, busy); end
        tick(HOLD + 10);

        press_set();
        press_enter(4'h4);
        sw = 4'h7;
        btn_set = 1'b1;
        btn_enter = 1'b1;
        tick(10);
        btn_set = 1'b0;
        btn_enter = 1'b0;
        tick(10);
        scan_display();
        for (int p = 0; p < 4; p++) begin
            vectors++;
            if (seen[p] !== 1'b1 || disp[p] !== BLANK) begin errors++; $display("[TB] FAIL same_cycle_pos%0d: got %h expected 7f", p, disp[p]); end
        end
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL same_cycle_busy: got %b expected 1", busy); end
    endtask

    task automatic test_reset_enter2();
        press_set();
        enter_code(16'h5555);
        press_enter(4'h5);
        press_enter(4'h5);
        do_reset();
        vectors++;
        if (code !== 16'h0101 || busy !== 1'b0 || an !== 4'hF || seg !== BLANK) begin
            errors++; $display("[TB] FAIL e2_reset: got code=%h busy=%b an=%h seg=%h expected 0101/0/f/7f", code, busy, an, seg);
        end
        press_set();
        enter_code(16'h6789);
        enter_code(16'h6789);
        vectors++;
        if (code !== 16'h6789 || code_valid !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL e2_reprogram: got code=%h valid=%b busy=%b expected 6789/1/0", code, code_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_mismatch();
        test_bounce();
        test_restart();
        test_reset_enter2();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
